// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM state type and the default bubble instruction.
package if_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_wait_timer.sv
// Fetch wait watchdog: counts consecutive stalled request cycles.
// Ports: clk_i, rst_ni, wait_i (count/clear), err_o (sticky timeout).
module if_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic wait_i,
  output logic err_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  always_comb begin
    cnt_d = '0;
    err_d = err_q;
    if (wait_i) begin
      cnt_d = (cnt_q == MAXC) ? cnt_q
                              : cnt_q + CW'(1);
      if (cnt_d == MAXC) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/if_fetch.sv
// IF stage: issues imem requests and fills the IF/ID register.
// Ports: clk, rst (async low), PC, hazards, imem bus, ID_*, imem_err.
// Build option IF_FETCH_TIMEOUT_EN enables the wait timeout flag.
module if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_DEFAULT,
  parameter int          MAX_WAIT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        Load_use_Flag,
  input  logic        Flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        Fetch_Stall,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_Instr,
  output logic        ID_Valid,
  output logic        imem_err
);

  fetch_state_e state_q;
  logic [31:0]  id_pc_q;
  logic [31:0]  id_instr_q;
  logic         id_valid_q;
  logic         in_req;

  assign in_req    = (state_q == S_REQ);
  assign imem_req  = in_req;
  assign imem_addr = PC;

  // Flush frees the PC so the redirect target loads at once.
  always_comb begin
    Fetch_Stall = 1'b1;
    if (in_req) Fetch_Stall = Flush ? 1'b0 : ~imem_ack;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      id_pc_q    <= '0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
    end else if (Flush) begin
      state_q    <= S_IDLE;
      id_pc_q    <= '0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
    end else if (Load_use_Flag) begin
      // PC is held upstream; same address is refetched.
      state_q <= S_REQ;
    end else if (in_req && imem_ack) begin
      state_q    <= S_REQ;
      id_pc_q    <= PC;
      id_instr_q <= imem_rdata;
      id_valid_q <= 1'b1;
    end else begin
      state_q    <= S_REQ;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
    end
  end

  assign ID_PC    = id_pc_q;
  assign ID_Instr = id_instr_q;
  assign ID_Valid = id_valid_q;

`ifdef IF_FETCH_TIMEOUT_EN
  logic wait_cyc;

  assign wait_cyc = in_req & ~imem_ack & ~Flush;

  if_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timer (
    .clk_i  (clk),
    .rst_ni (rst),
    .wait_i (wait_cyc),
    .err_o  (imem_err)
  );
`else
  assign imem_err = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: vector table plus
// hand sequences for timeout and mid-request reset.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_FETCH_TIMEOUT_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PC = '0;
  logic        Load_use_Flag = 1'b0;
  logic        Flush = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        Fetch_Stall;
  logic [31:0] ID_PC;
  logic [31:0] ID_Instr;
  logic        ID_Valid;
  logic        imem_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_fetch #(
    .NOP_INSTR (NOP),
    .MAX_WAIT  (15)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PC            (PC),
    .Load_use_Flag (Load_use_Flag),
    .Flush         (Flush),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .Fetch_Stall   (Fetch_Stall),
    .ID_PC         (ID_PC),
    .ID_Instr      (ID_Instr),
    .ID_Valid      (ID_Valid),
    .imem_err      (imem_err)
  );

  typedef struct {
    logic        fl;
    logic        lu;
    logic        ack;
    logic [31:0] pc;
    logic [31:0] rd;
    logic        req;
    logic        stall;
    logic        vld;
    logic [31:0] idpc;
    logic [31:0] idin;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic fl, input logic lu,
                     input logic ack, input logic [31:0] pc,
                     input logic [31:0] rd, input logic req,
                     input logic stall, input logic vld,
                     input logic [31:0] idpc,
                     input logic [31:0] idin);
    vec_t v;
    v.fl = fl; v.lu = lu; v.ack = ack;
    v.pc = pc; v.rd = rd; v.req = req;
    v.stall = stall; v.vld = vld;
    v.idpc = idpc; v.idin = idin;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_id(input string nm, input logic vld,
                        input logic [31:0] pc,
                        input logic [31:0] ins);
    n_vec++;
    if (ID_Valid !== vld || ID_PC !== pc || ID_Instr !== ins) begin
      n_err++;
      $display("FAIL %s: got v=%b pc=%h in=%h expected v=%b pc=%h in=%h",
               nm, ID_Valid, ID_PC, ID_Instr, vld, pc, ins);
    end
  endtask

  task automatic drive(input logic fl, input logic lu,
                       input logic ack, input logic [31:0] pc,
                       input logic [31:0] rd);
    Flush = fl; Load_use_Flag = lu; imem_ack = ack;
    PC = pc; imem_rdata = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // IDLE cycle right after reset release
    add(0,0,0,32'h00,32'h0,     0,1, 0,32'h00,NOP);
    add(0,0,1,32'h00,32'hA000,  1,0, 1,32'h00,32'hA000);
    add(0,0,1,32'h04,32'hA004,  1,0, 1,32'h04,32'hA004);
    add(0,0,1,32'h08,32'hA008,  1,0, 1,32'h08,32'hA008);
    add(0,0,1,32'h0C,32'hA00C,  1,0, 1,32'h0C,32'hA00C);
    // two wait cycles at 0x10
    add(0,0,0,32'h10,32'h0,     1,1, 0,32'h0C,NOP);
    add(0,0,0,32'h10,32'h0,     1,1, 0,32'h0C,NOP);
    add(0,0,1,32'h10,32'hB010,  1,0, 1,32'h10,32'hB010);
    add(0,0,1,32'h14,32'hB014,  1,0, 1,32'h14,32'hB014);
    add(0,0,1,32'h18,32'hB018,  1,0, 1,32'h18,32'hB018);
    add(0,0,1,32'h1C,32'hB01C,  1,0, 1,32'h1C,32'hB01C);
    add(0,0,1,32'h20,32'hB020,  1,0, 1,32'h20,32'hB020);
    // load-use: hold 0x20, ack dropped, 0x24 refetched
    add(0,1,1,32'h24,32'hB024,  1,0, 1,32'h20,32'hB020);
    add(0,0,1,32'h24,32'hB024,  1,0, 1,32'h24,32'hB024);
    add(0,0,1,32'h28,32'hB028,  1,0, 1,32'h28,32'hB028);
    add(0,0,1,32'h2C,32'hB02C,  1,0, 1,32'h2C,32'hB02C);
    // flush while waiting at 0x30, redirect to 0x100
    add(0,0,0,32'h30,32'h0,     1,1, 0,32'h2C,NOP);
    add(1,0,0,32'h30,32'h0,     1,0, 0,32'h00,NOP);
    add(0,0,1,32'h100,32'hDEAD, 0,1, 0,32'h00,NOP);
    add(0,0,0,32'h100,32'h0,    1,1, 0,32'h00,NOP);
    add(0,0,1,32'h100,32'hE100, 1,0, 1,32'h100,32'hE100);
    // flush and load-use together
    add(1,1,1,32'h104,32'hE104, 1,0, 0,32'h00,NOP);
    add(0,0,0,32'h104,32'h0,    0,1, 0,32'h00,NOP);
    add(0,0,1,32'h104,32'hE104, 1,0, 1,32'h104,32'hE104);
    // load-use during a wait cycle
    add(0,1,0,32'h108,32'h0,    1,1, 1,32'h104,32'hE104);

    drive(0,0,0,32'h0,32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'd0,imem_req}, 32'd0);
    chk("rst_err", {31'd0,imem_err}, 32'd0);
    chk_id("rst_id", 1'b0, 32'h0, NOP);

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].fl, tv[i].lu, tv[i].ack,
            tv[i].pc, tv[i].rd);
      #1;
      n_vec++;
      if (imem_req !== tv[i].req ||
          Fetch_Stall !== tv[i].stall ||
          imem_addr !== tv[i].pc) begin
        n_err++;
        $display("FAIL v%0d_bus: got req=%b st=%b a=%h expected req=%b st=%b a=%h",
                 i, imem_req, Fetch_Stall, imem_addr,
                 tv[i].req, tv[i].stall, tv[i].pc);
      end
      @(posedge clk);
      #1;
      chk_id($sformatf("v%0d_id", i), tv[i].vld,
             tv[i].idpc, tv[i].idin);
      @(negedge clk);
    end

    // timeout: clear with an ack, then 15 wait cycles
    drive(0,0,1,32'h108,32'hE108);
    @(posedge clk); #1;
    chk_id("to_ack", 1'b1, 32'h108, 32'hE108);
    @(negedge clk);
    drive(0,0,0,32'h10C,32'h0);
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      if (k == 14) chk("to_err14", {31'd0,imem_err}, 32'd0);
      if (k == 15) chk("to_err15", {31'd0,imem_err},
                       {31'd0,EXP_ERR});
      @(negedge clk);
    end
    #1;
    chk("to_stall", {31'd0,Fetch_Stall}, 32'd1);
    drive(0,0,1,32'h10C,32'hE10C);
    repeat (2) begin
      @(posedge clk); #1;
      chk("to_sticky", {31'd0,imem_err}, {31'd0,EXP_ERR});
      @(negedge clk);
      drive(0,0,1,32'h110,32'hE110);
    end

    // reset in the middle of a request
    drive(0,0,0,32'h114,32'h0);
    #1;
    chk("mr_req_pre", {31'd0,imem_req}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("mr_req", {31'd0,imem_req}, 32'd0);
    chk("mr_err", {31'd0,imem_err}, 32'd0);
    chk_id("mr_id", 1'b0, 32'h0, NOP);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_cyc1", {31'd0,imem_req}, 32'd0);
    @(posedge clk); #1;
    chk("mr_cyc2", {31'd0,imem_req}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h0000_0000, bubble instruction placed in ID_Instr.
REQ-002 SHALL have parameter MAX_WAIT, default 15, number of consecutive imem wait cycles that sets imem_err.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port PC  input  32  current fetch address from PC register.
REQ-006 SHALL have port Load_use_Flag  input  1  load-use hazard stall; ID-side registers hold.
REQ-007 SHALL have port Flush  input  1  taken branch/jump; kill fetched instruction.
REQ-008 SHALL have port imem_req  output  1  instruction memory request.
REQ-009 SHALL have port imem_addr  output  32  request address, combinationally equal to PC.
REQ-010 SHALL have port imem_ack  input  1  data valid on imem_rdata this cycle.
REQ-011 SHALL have port imem_rdata  input  32  instruction word.
REQ-012 SHALL have port Fetch_Stall  output  1  PC hold request, ORed with Load_use_Flag at the PC register.
REQ-013 SHALL have ports ID_PC, ID_Instr  output  32 each, and ID_Valid  output  1  IF/ID pipeline register contents.
REQ-014 SHALL have port imem_err  output  1  sticky fetch timeout flag.

Function
REQ-015 SHALL implement FSM states S_IDLE, S_REQ.
REQ-016 S_IDLE: imem_req=0, Fetch_Stall=1; next cycle -> S_REQ unconditionally.
REQ-017 S_REQ: imem_req=1; Fetch_Stall = ~imem_ack, except Fetch_Stall=0 when Flush=1.
REQ-018 Priority per cycle SHALL be Flush > Load_use_Flag > imem_ack.
REQ-019 Flush=1 (any state): ID_Valid<=0, ID_Instr<=NOP_INSTR, ID_PC<=0, FSM -> S_IDLE, any ack that cycle discarded.
REQ-020 Load_use_Flag=1, Flush=0: ID_PC, ID_Instr, ID_Valid hold; ack data that cycle discarded (PC is held, same address refetched next cycle); FSM stays S_REQ.
REQ-021 S_REQ, imem_ack=1, no Flush/Load_use: ID_PC<=PC, ID_Instr<=imem_rdata, ID_Valid<=1 on the same edge; fetch-to-ID latency one cycle for zero-wait memory.
REQ-022 S_REQ, imem_ack=0, no Flush/Load_use: ID_Valid<=0, ID_Instr<=NOP_INSTR (bubble), ID_PC holds.
REQ-023 imem_ack while in S_IDLE SHALL be ignored.
REQ-024 Zero-wait memory SHALL sustain one instruction per cycle with Fetch_Stall=0 continuously.

Reset
REQ-025 rst low SHALL immediately force: state S_IDLE, ID_PC=0, ID_Instr=NOP_INSTR, ID_Valid=0, imem_err=0, wait counter=0.
REQ-026 Reset asserted mid-request SHALL abandon the request (imem_req=0 during reset); first request issued second cycle after rst rises.

Configuration
REQ-027 Macro IF_FETCH_TIMEOUT_EN defined: a wait counter increments each S_REQ cycle with imem_ack=0, clears on ack, Flush, or leaving S_REQ; reaching MAX_WAIT sets imem_err, which stays 1 until reset; counter saturates.
REQ-028 Macro undefined: no counter logic; imem_err tied 0.

Structure
REQ-029 Shared package if_pkg SHALL hold the FSM state typedef and the default NOP constant.
REQ-030 Timeout logic SHALL be sub-module if_wait_timer, instantiated only under IF_FETCH_TIMEOUT_EN.

Verification
REQ-031 Reset release, zero-wait memory, PC 0,4,8 -> imem_req high from cycle 2; ID_PC 0,4,8 on consecutive cycles, ID_Valid=1, Fetch_Stall=0.
REQ-032 Memory inserts 2 wait cycles at PC=0x10 -> Fetch_Stall=1 two cycles, ID_Valid=0 with NOP_INSTR two cycles, then ID_PC=0x10 with rdata.
REQ-033 Load_use_Flag pulse one cycle with ID_PC=0x20 -> ID regs hold 0x20 for that edge, ack discarded, next fetch returns same PC.
REQ-034 Flush during wait at PC=0x30, redirect to 0x100 -> ID_Valid=0, one S_IDLE cycle, next request imem_addr=0x100; late ack ignored.
REQ-035 Flush and Load_use_Flag simultaneous -> bubble inserted (ID_Valid=0, ID_Instr=NOP_INSTR).
REQ-036 With IF_FETCH_TIMEOUT_EN, ack withheld 15 cycles -> imem_err=1 on 15th wait edge, remains 1 after later acks until rst low.
